// File: rtl/stopwatch_scan_core_pkg.sv
// Shared encodings for the stopwatch scan core: FSM states, per-slot anode
// patterns and the BCD digit ceiling.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam logic [3:0] AN_SLOT0 = 4'b1110;
   localparam logic [3:0] AN_SLOT1 = 4'b1101;
   localparam logic [3:0] AN_SLOT2 = 4'b1011;
   localparam logic [3:0] AN_SLOT3 = 4'b0111;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
      logic [3:0] an_sel;
      case (slot)
         2'd0:    an_sel = AN_SLOT0;
         2'd1:    an_sel = AN_SLOT1;
         2'd2:    an_sel = AN_SLOT2;
         default: an_sel = AN_SLOT3;
      endcase
      return an_sel;
   endfunction

endpackage

// File: rtl/stopwatch_scan_core_bcd_digit_cnt.sv
// One decade of the stopwatch count; carry is combinational so a rollover
// ripples through the whole chain on a single edge.
module bcd_digit_cnt
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] value,
   output logic       carry
);

   assign carry = inc && (value == BCD_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= 4'd0;
      else if (clr)
         value <= 4'd0;
      else if (inc)
         value <= carry ? 4'd0 : value + 4'd1;
   end

endmodule

// File: rtl/stopwatch_scan_core.sv
// Stopwatch core: SS.hh BCD count with run/pause/clear control and a
// one-digit-at-a-time display scan. Optional lap freeze: STOPWATCH_LAP_EN.
module stopwatch_scan_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 1000000,
   parameter int SCAN_DIV = 100000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap,
   output logic       lap_held,
`endif
   output logic [3:0] digit,
   output logic [3:0] an,
   output logic       dp,
   output logic       running,
   output logic       wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   sw_state_t        state, state_nxt;
   logic [PW-1:0]    presc;
   logic             tick;
   logic             zero_count;
   logic [4:0]       cy;
   logic [3:0][3:0]  live;
   logic [3:0][3:0]  shown;
   logic [SW-1:0]    scan_cnt;
   logic [1:0]       slot, slot_nxt;
   logic             scan_wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // start_stop beats clear in RUN; clear beats start_stop when stopped
   always_comb begin
      state_nxt  = state;
      zero_count = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clear)
               zero_count = 1'b1;
            else if (start_stop)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (start_stop)
               state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (clear) begin
               state_nxt  = ST_IDLE;
               zero_count = 1'b1;
            end else if (start_stop) begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign tick    = (state == ST_RUN) && (presc == PRESC_LAST);
   assign running = (state == ST_RUN);

   // Prescaler holds outside RUN so a resume finishes the partial tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc <= '0;
      else if (zero_count)
         presc <= '0;
      else if (state == ST_RUN)
         presc <= tick ? '0 : presc + PW'(1);
   end

   assign cy[0] = tick;

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit_cnt u_digit (
         .clk   (clk),
         .rst   (rst),
         .clr   (zero_count),
         .inc   (cy[i]),
         .value (live[i]),
         .carry (cy[i+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wrap <= 1'b0;
      else
         wrap <= cy[4];
   end

`ifdef STOPWATCH_LAP_EN
   logic [3:0][3:0] shadow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_held <= 1'b0;
         shadow   <= '0;
      end else if (start_stop || zero_count) begin
         lap_held <= 1'b0;
      end else if (lap && (state == ST_RUN)) begin
         lap_held <= !lap_held;
         if (!lap_held)
            shadow <= live;
      end
   end

   assign shown = lap_held ? shadow : live;
`else
   assign shown = live;
`endif

   assign scan_wrap = (scan_cnt == SCAN_LAST);
   assign slot_nxt  = scan_wrap ? slot + 2'd1 : slot;

   // digit/an/dp are all loaded from slot_nxt so they switch on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         slot     <= 2'd0;
         an       <= AN_SLOT0;
         dp       <= 1'b1;
         digit    <= 4'h0;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
         slot     <= slot_nxt;
         an       <= an_for_slot(slot_nxt);
         dp       <= (slot_nxt != 2'd2);
         digit    <= shown[slot_nxt];
      end
   end

endmodule
